uart_tx_arbiter: RTL and testbench

Shares the single UART transmit FIFO between N_REQ independent byte-stream requesters (e.g. APB register path, debug/log engine, DMA).
- Grants the FIFO write port to one requester at a time, round-robin.
- A grant is held for a whole message, ended by `req_last`, or until a burst cap or idle timeout is reached.
- Sits between the requesters and the UART controller's `tx_fifo_dataIn` / `tx_fifo_writeEn` / `tx_fifo_Full` port.

---
 rtl/uart_arb_pkg.sv | 34 +++
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART TX arbiter.
// Counter widths are derived from the top-level parameters through the functions below.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int unsigned DEF_N_REQ        = 4;
  localparam int unsigned DEF_MAX_BURST    = 16;
  localparam int unsigned DEF_IDLE_TIMEOUT = 32;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int unsigned GRANT_W = idx_w(DEF_N_REQ);
  localparam int unsigned BURST_W = cnt_w(DEF_MAX_BURST);
  localparam int unsigned IDLE_W  = cnt_w(DEF_IDLE_TIMEOUT);

  // Modulo-n add for small indices; n need not be a power of two.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set bit of req_i searching ptr_i, ptr_i+1, ... modulo N.
// Purely combinational, no backpressure; found_o is low when req_i is all zero.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'(wrap_add(int'(ptr_i), k, int'(N)));
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART TX FIFO write port; one IDLE cycle to grant, zero-latency beats.
// tx_fifo_Full drops req_ready of the granted requester and freezes the idle timer, so backpressure never times out.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         tx_fifo_dataIn,
  output logic                      tx_fifo_writeEn,
  input  logic                      tx_fifo_Full,
  output logic [idx_w(N_REQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int unsigned GW = idx_w(N_REQ);
  localparam int unsigned BW = cnt_w(MAX_BURST);
  localparam int unsigned IW = cnt_w(IDLE_TIMEOUT);

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic              g_valid, g_last;
  logic [DATA_W-1:0] g_data;
  logic              in_xfer, accept, idle_tick, burst_done, idle_done, rel_now;

  uart_rr_pick #(
    .N (N_REQ),
    .W (GW)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Reset gates the outputs so an abandoned message cannot write in the reset cycle.
  assign in_xfer    = (state_q == XFER) && !reset;
  assign accept     = in_xfer && g_valid && !tx_fifo_Full;
  assign idle_tick  = in_xfer && !g_valid && !tx_fifo_Full;
  assign burst_done = burst_cnt_q >= BW'(MAX_BURST - 1);
  assign idle_done  = idle_cnt_q >= IW'(IDLE_TIMEOUT - 1);
  assign rel_now    = (accept && (g_last || burst_done)) || (idle_tick && idle_done);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = in_xfer && (grant_id_q == GW'(i)) && !tx_fifo_Full;
    end
    tx_fifo_writeEn = accept;
    tx_fifo_dataIn  = in_xfer ? g_data : '0;
    busy            = in_xfer;
    grant_id        = grant_id_q;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          if (burst_cnt_q != BW'(MAX_BURST)) burst_cnt_d = burst_cnt_q + 1'b1;
          idle_cnt_d = '0;
        end else if (idle_tick && (idle_cnt_q != IW'(IDLE_TIMEOUT))) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (rel_now) begin
          state_d = IDLE;
          ptr_d   = (grant_id_q == GW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed multi-cycle sequences, and randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 16;
  localparam int TO   = 32;

  logic        clk, reset;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0]  tx_fifo_dataIn;
  logic        tx_fifo_writeEn, tx_fifo_Full, busy;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(
    .N_REQ(N), .DATA_W(8), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_fifo_dataIn(tx_fifo_dataIn), .tx_fifo_writeEn(tx_fifo_writeEn), .tx_fifo_Full(tx_fifo_Full),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- requester drivers ----------------
  logic [7:0] q_dat[N][$];
  logic       q_last[N][$];
  logic [3:0] pres, mute, acc_mask;
  int         pause[N];
  int         gap_pct;
  logic       rst_cmd, full_cmd;

  task automatic load_msg(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      q_dat[r].push_back(base + 8'(k));
      q_last[r].push_back(k == len - 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] && q_dat[i].size() > 0) begin
        void'(q_dat[i].pop_front());
        void'(q_last[i].pop_front());
        pres[i] = 1'b0;
      end
    end
    #1;
    reset        = rst_cmd;
    tx_fifo_Full = full_cmd;
    for (int i = 0; i < N; i++) begin
      if (!pres[i]) begin
        if (pause[i] > 0) pause[i]--;
        else if (!mute[i] && q_dat[i].size() > 0 && int'($urandom_range(99)) >= gap_pct) pres[i] = 1'b1;
      end
      if (pres[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = q_dat[i][0];
        req_last[i]         = q_last[i][0];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model and write log ----------------
  typedef struct { int own; logic [7:0] dat; int cyc; } wr_t;
  wr_t wr_log[$];

  int   m_own = -1, m_ptr = 0, m_gid = 0, m_beats = 0, m_idle = 0, mj = 0, cyc = 0;
  bit   mon_en = 0;
  logic [3:0] prev_hold = '0, prev_last = '0;
  logic [31:0] prev_dat = '0;

  task automatic monitor_cycle();
    logic [3:0] e_rdy;
    logic       e_wen, e_busy, rel;
    logic [7:0] e_din;
    wr_t        w;
    cyc++;
    if (!mon_en && reset) mon_en = 1;
    if (!mon_en) return;
    e_rdy = '0; e_wen = 0; e_busy = 0; e_din = '0; rel = 0;
    if (!reset && m_own >= 0) begin
      e_busy        = 1'b1;
      e_rdy[m_own]  = !tx_fifo_Full;
      e_wen         = req_valid[m_own] && !tx_fifo_Full;
      e_din         = req_data[m_own*8 +: 8];
    end
    chk("model_busy", busy, e_busy);
    chk("model_ready", req_ready, e_rdy);
    chk("model_writeEn", tx_fifo_writeEn, e_wen);
    chk("model_dataIn", tx_fifo_dataIn, e_din);
    if (!reset) chk("model_grant_id", grant_id, m_gid);
    for (int i = 0; i < N; i++) begin
      if (prev_hold[i] && req_valid[i])
        chk("protocol_hold", {prev_last[i], prev_dat[i*8 +: 8]}, {req_last[i], req_data[i*8 +: 8]});
      prev_hold[i] = req_valid[i] && !req_ready[i] && !reset;
    end
    prev_dat  = req_data;
    prev_last = req_last;
    acc_mask  = req_valid & req_ready;
    if (tx_fifo_writeEn) begin
      w.own = int'(grant_id); w.dat = tx_fifo_dataIn; w.cyc = cyc;
      wr_log.push_back(w);
    end
    // Advance the model to the state seen after the coming clock edge.
    if (reset) begin
      m_own = -1; m_ptr = 0; m_gid = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        mj = (m_ptr + k) % N;
        if (m_own < 0 && req_valid[mj]) begin
          m_own = mj; m_gid = mj; m_beats = 0; m_idle = 0;
        end
      end
    end else begin
      if (e_wen) begin
        m_beats++; m_idle = 0;
        rel = req_last[m_own] || (m_beats == MAXB);
      end else if (!tx_fifo_Full && !req_valid[m_own]) begin
        m_idle++;
        rel = (m_idle == TO);
      end
      if (rel) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_cycle();
    end
  end

  // ---------------- helpers for directed sequences ----------------
  int         exp_own[$];
  logic [7:0] exp_dat[$];

  task automatic expect_bytes(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      exp_own.push_back(r);
      exp_dat.push_back(base + 8'(k));
    end
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_count"}, wr_log.size(), exp_own.size());
    for (int k = 0; k < exp_own.size() && k < wr_log.size(); k++)
      chk($sformatf("%s_byte%0d", nm, k), {8'(wr_log[k].own), wr_log[k].dat}, {8'(exp_own[k]), exp_dat[k]});
    exp_own.delete();
    exp_dat.delete();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (q_dat[i].size() != 0) return 0;
    return (pres == 4'b0) && !busy;
  endfunction

  task automatic drain(input string nm, input int limit);
    int n;
    n = 0;
    while (!all_idle() && n < limit) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, all_idle(), 1);
  endtask

  task automatic wait_writes(input string nm, input int cnt);
    int n;
    n = 0;
    while (wr_log.size() < cnt && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_reached_writes"}, wr_log.size() >= cnt, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, full; logic [3:0] v, l; logic [31:0] d;
    logic [3:0] e_rdy; logic e_wen; logic [7:0] e_din; logic e_busy; logic [1:0] e_gid;
  } vec_t;
  vec_t tbl[16];

  int cnt, t0;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 4'h4, 4'h0, 32'h0041_0000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 4'h4, 4'h0, 32'h0041_0000, 4'h4, 1'b1, 8'h41, 1'b1, 2'd2};
    tbl[3]  = '{1'b0, 1'b0, 4'h4, 4'h0, 32'h0042_0000, 4'h4, 1'b1, 8'h42, 1'b1, 2'd2};
    tbl[4]  = '{1'b0, 1'b0, 4'h4, 4'h4, 32'h0043_0000, 4'h4, 1'b1, 8'h43, 1'b1, 2'd2};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2};
    tbl[6]  = '{1'b0, 1'b0, 4'h5, 4'h5, 32'h0044_0010, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2};
    tbl[7]  = '{1'b0, 1'b0, 4'h5, 4'h5, 32'h0044_0010, 4'h1, 1'b1, 8'h10, 1'b1, 2'd0};
    tbl[8]  = '{1'b0, 1'b0, 4'h4, 4'h4, 32'h0044_0000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 4'h4, 4'h4, 32'h0044_0000, 4'h0, 1'b0, 8'h44, 1'b1, 2'd2};
    tbl[10] = '{1'b0, 1'b0, 4'h4, 4'h4, 32'h0044_0000, 4'h4, 1'b1, 8'h44, 1'b1, 2'd2};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2};
    tbl[12] = '{1'b1, 1'b0, 4'h4, 4'h4, 32'h0044_0000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2};
    tbl[13] = '{1'b0, 1'b0, 4'h4, 4'h4, 32'h0044_0000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[14] = '{1'b0, 1'b0, 4'h4, 4'h4, 32'h0044_0000, 4'h4, 1'b1, 8'h44, 1'b1, 2'd2};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2};

    reset = 1'b1; tx_fifo_Full = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    pres = '0; mute = '0; acc_mask = '0; gap_pct = 0; rst_cmd = 1'b1; full_cmd = 1'b0;
    for (int i = 0; i < N; i++) pause[i] = 0;

    tick();
    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #1;
      reset = tbl[r].rst; tx_fifo_Full = tbl[r].full;
      req_valid = tbl[r].v; req_last = tbl[r].l; req_data = tbl[r].d;
      @(negedge clk); #1;
      chk($sformatf("vec%0d_ready", r), req_ready, tbl[r].e_rdy);
      chk($sformatf("vec%0d_writeEn", r), tx_fifo_writeEn, tbl[r].e_wen);
      chk($sformatf("vec%0d_dataIn", r), tx_fifo_dataIn, tbl[r].e_din);
      chk($sformatf("vec%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("vec%0d_grant_id", r), grant_id, tbl[r].e_gid);
    end

    // Contention from ptr = 0: whole messages in order 0, 1, 3 with one IDLE cycle between grants.
    rst_cmd = 1'b0; full_cmd = 1'b0;
    rst_cmd = 1'b1; tick(); rst_cmd = 1'b0;
    wr_log.delete();
    load_msg(0, 2, 8'h11); load_msg(1, 2, 8'h21); load_msg(3, 2, 8'h31);
    drain("contend", 100);
    if (wr_log.size() == 6) begin
      chk("contend_cyc1", wr_log[1].cyc - wr_log[0].cyc, 1);
      chk("contend_cyc2", wr_log[2].cyc - wr_log[0].cyc, 3);
      chk("contend_cyc3", wr_log[3].cyc - wr_log[0].cyc, 4);
      chk("contend_cyc4", wr_log[4].cyc - wr_log[0].cyc, 6);
      chk("contend_cyc5", wr_log[5].cyc - wr_log[0].cyc, 7);
    end
    expect_bytes(0, 2, 8'h11); expect_bytes(1, 2, 8'h21); expect_bytes(3, 2, 8'h31);
    check_log("contend");

    // Burst cap: move ptr to 1, then req 1 streams 20 bytes while req 0 waits.
    load_msg(0, 1, 8'h01);
    drain("burst_setup", 50);
    wr_log.delete();
    load_msg(1, 20, 8'h80); load_msg(0, 2, 8'hA0);
    drain("burst", 200);
    if (wr_log.size() == 22) chk("burst_rotate_gap", wr_log[16].cyc - wr_log[15].cyc, 2);
    expect_bytes(1, 16, 8'h80); expect_bytes(0, 2, 8'hA0); expect_bytes(1, 4, 8'h90);
    check_log("burst");

    // Backpressure: Full held 50 cycles after two bytes of a four-byte message.
    wr_log.delete();
    load_msg(2, 4, 8'h50);
    wait_writes("bp", 2);
    full_cmd = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk($sformatf("bp_ready_c%0d", k), req_ready, 4'h0);
      chk($sformatf("bp_writeEn_c%0d", k), tx_fifo_writeEn, 1'b0);
      chk($sformatf("bp_busy_c%0d", k), busy, 1'b1);
    end
    full_cmd = 1'b0;
    drain("bp", 50);
    if (wr_log.size() == 4) chk("bp_resume_gap", wr_log[2].cyc - wr_log[1].cyc, 51);
    expect_bytes(2, 4, 8'h50);
    check_log("bp");

    // Idle timeout: req 0 goes silent after its first byte while req 1 waits.
    wr_log.delete();
    load_msg(0, 3, 8'hB0); load_msg(1, 1, 8'hC0);
    wait_writes("to", 1);
    if (wr_log.size() > 0) chk("to_first_owner", wr_log[0].own, 0);
    mute[0] = 1'b1;
    cnt = 0;
    tick();
    while (busy && grant_id == 2'd0 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("to_idle_cycles", cnt, TO);
    chk("to_release_busy", busy, 1'b0);
    tick();
    chk("to_regrant_busy", busy, 1'b1);
    chk("to_regrant_id", grant_id, 2'd1);
    mute[0] = 1'b0;
    drain("to", 100);

    // Reset while req 3 holds the grant after five bytes.
    wr_log.delete();
    load_msg(3, 8, 8'h60);
    wait_writes("rst", 5);
    rst_cmd = 1'b1;
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_writeEn", tx_fifo_writeEn, 1'b0);
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_dataIn", tx_fifo_dataIn, 8'h00);
    chk("rst_write_count", wr_log.size(), 5);
    rst_cmd = 1'b0;
    for (int i = 0; i < N; i++) begin
      q_dat[i].delete(); q_last[i].delete();
    end
    pres = '0;
    load_msg(0, 1, 8'h70); load_msg(3, 1, 8'h71);
    tick();
    chk("rst_after_busy", busy, 1'b0);
    chk("rst_after_grant_id", grant_id, 2'd0);
    tick();
    chk("rst_first_grant", grant_id, 2'd0);
    chk("rst_first_data", tx_fifo_dataIn, 8'h70);
    drain("rst", 50);

    // Randomized traffic: gaps, pauses long enough to time out, random Full, long messages.
    gap_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      full_cmd = ($urandom_range(99) < 15);
      for (int i = 0; i < N; i++) begin
        if (q_dat[i].size() == 0 && $urandom_range(99) < 5)
          load_msg(i, int'($urandom_range(1, 24)), 8'($urandom));
        if (pause[i] == 0 && $urandom_range(999) < 8)
          pause[i] = int'($urandom_range(20, 45));
      end
      tick();
    end
    full_cmd = 1'b0; gap_pct = 0;
    for (int i = 0; i < N; i++) pause[i] = 0;
    drain("random", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
